bus_slave: RTL
==============

Name: bus_slave

Overview:
- Serial bus slave: the responder end of the bus master's serial protocol.
- Deserialises 14-bit address frames and 8-bit data on per-bit lines, and stores write data in a local byte memory.
- Returns read data serially, with a one-cycle slave_valid strobe before each byte.
- Supports single and burst (8..512 beat) writes and reads; sits behind the bus decoder, so it sees master_valid only when selected.

Parameters:
- MEM_AW, 12, word-address width of local memory (depth 2^MEM_AW bytes); address bits [MEM_AW-1:0] used, upper bits ignored.
- ADDR_BITS, 14, serial address length.
- DATA_BITS, 8, serial data length.

Ports:
- clock  in  1  system clock, all sampling on rising edge
- reset  in  1  asynchronous, active-low reset
- master_valid  in  1  frame/beat valid from master, high for the whole frame
- write_en  in  1  1=write, 0=read; sampled on the first address bit
- addr_rx  in  1  serial address, MSB first
- data_rx  in  1  serial write data, MSB first
- burst_rx  in  1  burst flag, then 3 mode bits
- data_tx  out  1  serial read data, MSB first
- slave_valid  out  1  one-cycle strobe preceding each read byte
- slave_ready  out  1  slave can accept a new frame or burst-write beat
- busy  out  1  transaction in progress

Behaviour:
- Reset (async, low): state IDLE; all counters cleared; data_tx, slave_valid, busy = 0; slave_ready = 0.
  - slave_ready = 1 from the first edge after reset release. Memory contents are not cleared.
- Frame start: in IDLE and BW_WAIT, only a 0->1 edge of master_valid, taken from a registered copy, starts a frame or beat. A level held high never retriggers.
- Frame timing: bit k (k = 1..14) is sampled on the k-th edge with master_valid = 1, the first being the start edge.
  - addr_rx carries addr[14-k].
  - For writes, data_rx carries data[14-k] on k = 7..14.
  - burst_rx = 1 on k = 1 flags burst; burst_rx on k = 12..14 carries mode[2:0], MSB first.
- Burst length: mode 0 = single; mode m = 1..7 gives 8<<(m-1) beats (8, 16, ..., 512), held in a 10-bit beat counter.
- States: IDLE, RX_FRAME, WR_COMMIT, BW_WAIT, BW_DATA, RD_FETCH, RD_VALID, RD_SHIFT.
- IDLE: slave_ready = 1, busy = 0. A master_valid rise moves to RX_FRAME, with busy = 1 and slave_ready = 0 from the next edge.
- RX_FRAME: shift 14 bits.
  - master_valid low before bit 14: abort to IDLE, no memory access.
  - After bit 14, go to WR_COMMIT if write, otherwise RD_FETCH.
- WR_COMMIT: 1 cycle; mem[addr] <= data.
  - Single write: go to IDLE.
  - Burst write: beat = 1, go to BW_WAIT.
- BW_WAIT: slave_ready = 1.
  - If beat == length, go to IDLE.
  - On a master_valid rise, sample data bit 7 and go to BW_DATA.
- BW_DATA: sample the remaining 7 bits, then commit mem[addr+beat] in the cycle after bit 8; beat += 1; go to BW_WAIT.
  - master_valid low mid-beat: abort to IDLE; earlier beats remain written.
- RD_FETCH: 1 cycle; synchronous read of mem[addr+beat], with beat = 0 initially.
- RD_VALID: slave_valid = 1 for exactly 1 cycle; data_tx = 0.
- RD_SHIFT: 8 cycles, data_tx = byte[7] down to byte[0].
  - Then beat += 1. If beat < length (length 1 for single), go to RD_FETCH, else go to IDLE.
  - Each read beat is 10 cycles.
  - slave_valid rises 2 edges after the edge sampling address bit 14.
- Address arithmetic: addr + beat is truncated to MEM_AW bits and wraps to word 0 past the top.
- master_valid rise outside IDLE/BW_WAIT: ignored (protocol violation); no state change.
- Reset mid-transaction: immediate return to IDLE. A write commit in progress at that edge is not guaranteed.

Decomposition:
- Shared package slave_pkg holds:
  - the state enum;
  - frame constants ADDR_BITS = 14, DATA_BITS = 8, MODE_BITS = 3, DATA_FIRST_BIT = 7, MODE_FIRST_BIT = 12;
  - a burst_len(mode) function returning 10 bits.
- Sub-module slave_mem: single-port synchronous RAM, 2^MEM_AW x 8, 1-cycle read latency, write enable. The same memory module is reused by other slaves.

Test Plan:
- Single write addr 0x0A5, data 0x3C, then single read addr 0x0A5 -> slave_valid pulse 2 edges after the last address bit; data_tx = 0,0,1,1,1,1,0,0; busy low afterwards.
- Burst write mode 1 at 0x0FF, beats 0x10..0x17 with valid rising after each slave_ready -> mem[0x0FF..0x106] = 0x10..0x17; slave_ready high between beats; IDLE after beat 8.
- Burst read mode 1 at 0xFFC (MEM_AW = 12) -> 8 strobes, 10 cycles apart, returning mem[0xFFC..0xFFF, 0x000..0x003] (wrap-around).
- Write frame with master_valid dropped after 9 bits -> IDLE, target location unchanged, then a following full frame is accepted normally.
- Assert reset during the RD_SHIFT of beat 3 of a burst read -> outputs 0 asynchronously; slave_ready = 1 one edge after release; memory contents preserved.
- master_valid held high across the end of a single write -> no second frame until valid goes low and rises again.

Source files
------------

// File: rtl/slave_pkg.sv
// Shared definitions for the serial bus slave.
//   - state_t    : controller state encoding
//   - frame constants (address/data/mode lengths and the frame bit positions where
//     write data and burst mode start)
//   - burst_len(): beat count for a 3-bit burst mode (0 = single beat)
package slave_pkg;

    localparam int unsigned ADDR_BITS      = 14;
    localparam int unsigned DATA_BITS      = 8;
    localparam int unsigned MODE_BITS      = 3;
    localparam int unsigned DATA_FIRST_BIT = 7;
    localparam int unsigned MODE_FIRST_BIT = 12;
    localparam int unsigned BEAT_W         = 10;

    typedef enum logic [2:0] {
        StIdle,
        StRxFrame,
        StWrCommit,
        StBwWait,
        StBwData,
        StRdFetch,
        StRdValid,
        StRdShift
    } state_t;

    // Mode 0 is a single beat; mode m gives 8 << (m-1) beats (8..512).
    function automatic logic [BEAT_W-1:0] burst_len(input logic [MODE_BITS-1:0] mode);
        if (mode == '0) begin
            return BEAT_W'(1);
        end
        return BEAT_W'(8) << (mode - 1'b1);
    endfunction

endpackage

// File: rtl/slave_mem.sv
// Single-port synchronous byte RAM shared by the bus slaves.
//   clock : write and read both registered on the rising edge
//   we    : write wdata to mem[addr]
//   re    : load mem[addr] into rdata (one-cycle read latency; rdata holds otherwise)
//   addr  : word address
//   wdata : write data
//   rdata : registered read data
// Contents are not reset.
module slave_mem #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 8
) (
    input  logic          clock,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem_q[addr];
        end
    end

endmodule

// File: rtl/bus_slave.sv
// Serial bus slave: responder end of the bus master's bit-serial protocol.
//   clock        : system clock, rising-edge sampling
//   reset        : asynchronous, active-low
//   master_valid : frame / burst-beat valid, high for the whole frame or beat
//   write_en     : 1 = write, 0 = read (taken on the first frame bit)
//   addr_rx      : serial address, MSB first
//   data_rx      : serial write data, MSB first
//   burst_rx     : burst flag on the first bit, mode[2:0] on the last three bits
//   data_tx      : serial read data, MSB first
//   slave_valid  : one-cycle strobe ahead of each read byte
//   slave_ready  : slave accepts a new frame or burst-write beat
//   busy         : transaction in progress
module bus_slave #(
    parameter int unsigned MEM_AW    = 12,
    parameter int unsigned ADDR_BITS = slave_pkg::ADDR_BITS,
    parameter int unsigned DATA_BITS = slave_pkg::DATA_BITS
) (
    input  logic clock,
    input  logic reset,
    input  logic master_valid,
    input  logic write_en,
    input  logic addr_rx,
    input  logic data_rx,
    input  logic burst_rx,
    output logic data_tx,
    output logic slave_valid,
    output logic slave_ready,
    output logic busy
);

    import slave_pkg::*;

    localparam int unsigned CNT_W = $clog2(ADDR_BITS + 1);

    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_BITS);
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_BITS);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_K     = CNT_W'(DATA_FIRST_BIT);
    localparam logic [CNT_W-1:0] MODE_K     = CNT_W'(MODE_FIRST_BIT);

    state_t               state_q, state_d;
    logic                 mv_q;
    logic                 started_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     bit_k;
    logic [MEM_AW-1:0]    addr_q, addr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [MODE_BITS-1:0] mode_q, mode_d;
    logic                 wr_q, wr_d;
    logic                 burst_q, burst_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [BEAT_W-1:0]    beat_inc;
    logic [BEAT_W-1:0]    len;
    logic                 mv_rise;

    logic                 mem_we;
    logic                 mem_re;
    logic [MEM_AW-1:0]    mem_addr;
    logic [DATA_BITS-1:0] mem_rdata;

    // Only a 0->1 transition starts a frame or beat; a held level never retriggers.
    assign mv_rise  = master_valid & ~mv_q;
    // 1-based index of the frame bit sampled on this edge.
    assign bit_k    = cnt_q + 1'b1;
    assign beat_inc = beat_q + 1'b1;
    assign len      = burst_q ? burst_len(mode_q) : BEAT_W'(1);
    // Burst addresses wrap within the local memory.
    assign mem_addr = addr_q + MEM_AW'(beat_q);

    assign busy        = (state_q != StIdle);
    assign slave_ready = started_q & ((state_q == StIdle) | (state_q == StBwWait));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            mv_q      <= 1'b0;
            started_q <= 1'b0;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            mode_q    <= '0;
            wr_q      <= 1'b0;
            burst_q   <= 1'b0;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            mv_q      <= master_valid;
            started_q <= 1'b1;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            mode_q    <= mode_d;
            wr_q      <= wr_d;
            burst_q   <= burst_d;
            beat_q    <= beat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        mode_d      = mode_q;
        wr_d        = wr_q;
        burst_d     = burst_q;
        beat_d      = beat_q;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        slave_valid = 1'b0;
        data_tx     = 1'b0;

        case (state_q)
            StIdle: begin
                if (mv_rise) begin
                    // Start edge carries frame bit 1.
                    addr_d  = {addr_q[MEM_AW-2:0], addr_rx};
                    wr_d    = write_en;
                    burst_d = burst_rx;
                    mode_d  = '0;
                    beat_d  = '0;
                    cnt_d   = CNT_W'(1);
                    state_d = StRxFrame;
                end
            end

            StRxFrame: begin
                if (cnt_q == ADDR_LAST) begin
                    // Frame complete; master_valid is don't-care in this cycle.
                    cnt_d   = '0;
                    state_d = wr_q ? StWrCommit : StRdFetch;
                end else if (!master_valid) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d  = bit_k;
                    addr_d = {addr_q[MEM_AW-2:0], addr_rx};
                    if (bit_k >= DATA_K) begin
                        data_d = {data_q[DATA_BITS-2:0], data_rx};
                    end
                    if (bit_k >= MODE_K) begin
                        mode_d = {mode_q[MODE_BITS-2:0], burst_rx};
                    end
                end
            end

            StWrCommit: begin
                mem_we = 1'b1;
                if (len == BEAT_W'(1)) begin
                    state_d = StIdle;
                end else begin
                    beat_d  = BEAT_W'(1);
                    state_d = StBwWait;
                end
            end

            StBwWait: begin
                if (beat_q == len) begin
                    state_d = StIdle;
                end else if (mv_rise) begin
                    data_d  = {data_q[DATA_BITS-2:0], data_rx};
                    cnt_d   = CNT_W'(1);
                    state_d = StBwData;
                end
            end

            StBwData: begin
                if (cnt_q == DATA_LAST) begin
                    // Beat complete: commit in the cycle after its last bit.
                    mem_we  = 1'b1;
                    beat_d  = beat_inc;
                    cnt_d   = '0;
                    state_d = StBwWait;
                end else if (!master_valid) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    data_d = {data_q[DATA_BITS-2:0], data_rx};
                    cnt_d  = bit_k;
                end
            end

            StRdFetch: begin
                mem_re  = 1'b1;
                state_d = StRdValid;
            end

            StRdValid: begin
                slave_valid = 1'b1;
                data_d      = mem_rdata;
                cnt_d       = '0;
                state_d     = StRdShift;
            end

            StRdShift: begin
                data_tx = data_q[DATA_BITS-1];
                data_d  = {data_q[DATA_BITS-2:0], 1'b0};
                if (cnt_q == SHIFT_LAST) begin
                    cnt_d   = '0;
                    beat_d  = beat_inc;
                    state_d = (beat_inc < len) ? StRdFetch : StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    slave_mem #(
        .AW (MEM_AW),
        .DW (DATA_BITS)
    ) u_mem (
        .clock (clock),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (data_q),
        .rdata (mem_rdata)
    );

endmodule
